// File: rtl/regfl_wr_ctrl_pkg.sv
// Shared types and defaults for the register-file write-port controller.
// Holds the FSM state encoding and the default geometry of the file.
package regfl_wr_ctrl_pkg;

  localparam int DEF_W      = 3;
  localparam int DEF_RGST_W = 64;
  localparam int DEF_N_REQ  = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SWEEP = 1'b1
  } wr_state_e;

  // Width of a round-robin pointer/index for n requesters (never below 1 bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfl_wr_ctrl_rr_arb.sv
// Combinational round-robin arbiter: grants the first requester at or above
// ptr_i, wrapping to the lowest requester when none remain above it.
module regfl_wr_ctrl_rr_arb #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [N-1:0] hi;
  logic [N-1:0] hi_first;
  logic [N-1:0] all_first;

  for (genvar gi = 0; gi < N; gi++) begin : g_hi
    assign hi[gi] = req_i[gi] & (PW'(gi) >= ptr_i);
  end

  // x & -x isolates the lowest set bit, i.e. the first candidate in search order.
  assign hi_first  = hi & (~hi + N'(1));
  assign all_first = req_i & (~req_i + N'(1));
  assign gnt_o     = (|hi) ? hi_first : all_first;
  assign any_o     = |req_i;

  for (genvar bi = 0; bi < PW; bi++) begin : g_enc
    logic [N-1:0] sel;
    for (genvar gi = 0; gi < N; gi++) begin : g_sel
      if (((gi >> bi) & 1) == 1) begin : g_on
        assign sel[gi] = gnt_o[gi];
      end else begin : g_off
        assign sel[gi] = 1'b0;
      end
    end
    assign gnt_idx_o[bi] = |sel;
  end

endmodule

// File: rtl/regfl_wr_ctrl.sv
// Write-port controller for regfl: round-robin merges N_REQ writers onto the
// single we/s/d port and runs a zero-fill sweep of every register on request.
module regfl_wr_ctrl
  import regfl_wr_ctrl_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int RGST_W = DEF_RGST_W,
  parameter int N_REQ  = DEF_N_REQ
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_vld,
  input  logic [N_REQ*W-1:0]      req_addr,
  input  logic [N_REQ*RGST_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_rdy,
  input  logic                    init_req,
  output logic                    rf_we,
  output logic [W-1:0]            rf_s,
  output logic [RGST_W-1:0]       rf_d,
  output logic                    busy,
  output logic                    init_done
);

  localparam int PW = ptr_width(N_REQ);

  wr_state_e          state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [W:0]         cnt_q, cnt_d;
  logic               rf_we_q, rf_we_d;
  logic [W-1:0]       rf_s_q, rf_s_d;
  logic [RGST_W-1:0]  rf_d_q, rf_d_d;
  logic               done_q, done_d;

  logic [N_REQ-1:0]   gnt;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [W-1:0]       addr_arr [N_REQ];
  logic [RGST_W-1:0]  data_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*W +: W];
    assign data_arr[gi] = req_data[gi*RGST_W +: RGST_W];
  end

  regfl_wr_ctrl_rr_arb #(
    .N  (N_REQ),
    .PW (PW)
  ) u_arb (
    .req_i     (req_vld),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rf_we_q <= 1'b0;
      rf_s_q  <= '0;
      rf_d_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rf_we_q <= rf_we_d;
      rf_s_q  <= rf_s_d;
      rf_d_q  <= rf_d_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rf_we_d = 1'b0;
    rf_s_d  = rf_s_q;
    rf_d_d  = rf_d_q;
    done_d  = 1'b0;
    req_rdy = '0;
    case (state_q)
      ST_RUN: begin
        // A sweep request pre-empts any pending writer for this cycle.
        if (init_req) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end else begin
          req_rdy = gnt;
          if (gnt_any) begin
            rf_we_d = 1'b1;
            rf_s_d  = addr_arr[gnt_idx];
            rf_d_d  = data_arr[gnt_idx];
            ptr_d   = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + PW'(1);
          end
        end
      end
      ST_SWEEP: begin
        // The extra counter bit marks the trailing cycle after the last write.
        if (!cnt_q[W]) begin
          rf_we_d = 1'b1;
          rf_s_d  = cnt_q[W-1:0];
          rf_d_d  = '0;
          done_d  = (cnt_q[W-1:0] == {W{1'b1}});
          cnt_d   = cnt_q + {{W{1'b0}}, 1'b1};
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign rf_we     = rf_we_q;
  assign rf_s      = rf_s_q;
  assign rf_d      = rf_d_q;
  assign init_done = done_q;
  assign busy      = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_regfl_wr_ctrl.sv
// Bench for regfl_wr_ctrl with a behavioural register file on its write port;
// directed vector table, hand-built sweep/abort sequences and a random run.
module tb_regfl_wr_ctrl;

  localparam int W  = 3;
  localparam int RW = 64;
  localparam int NQ = 4;
  localparam int NR = 1 << W;

  logic            clk;
  logic            rst;
  logic [NQ-1:0]   req_vld;
  logic [NQ*W-1:0] req_addr;
  logic [NQ*RW-1:0] req_data;
  logic [NQ-1:0]   req_rdy;
  logic            init_req;
  logic            rf_we;
  logic [W-1:0]    rf_s;
  logic [RW-1:0]   rf_d;
  logic            busy;
  logic            init_done;

  regfl_wr_ctrl #(.W(W), .RGST_W(RW), .N_REQ(NQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vld   (req_vld),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .init_req  (init_req),
    .rf_we     (rf_we),
    .rf_s      (rf_s),
    .rf_d      (rf_d),
    .busy      (busy),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester-side holding registers.
  logic [W-1:0]  a_q [NQ];
  logic [RW-1:0] d_q [NQ];

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NQ; i++) begin
      req_addr[i*W +: W]   = a_q[i];
      req_data[i*RW +: RW] = d_q[i];
    end
  end

  // Behavioural regfl: register 0 sits in the MSBs of q.
  logic [RW-1:0]    rf_arr [NR];
  logic [NR*RW-1:0] q;
  always @(posedge clk) if (rf_we) rf_arr[rf_s] <= rf_d;
  always_comb begin
    q = '0;
    for (int k = 0; k < NR; k++) q[(NR-k)*RW-1 -: RW] = rf_arr[k];
  end

  function automatic logic [RW-1:0] q_reg(input int k);
    return q[(NR-k)*RW-1 -: RW];
  endfunction

  function automatic logic [RW-1:0] dgen(input int i, input logic [W-1:0] a);
    return 64'hA5 | (64'(i) << 40) | (64'(a) << 8);
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: phase -1 means normal operation, 0..NR walks the sweep.
  int            m_ptr;
  int            m_phase;
  logic          e_we;
  logic [W-1:0]  e_s;
  logic [RW-1:0] e_d;
  logic          e_done;
  logic [RW-1:0] m_mem [NR];

  function automatic int rr_pick(input logic [NQ-1:0] v, input int p);
    for (int k = 0; k < NQ; k++) if (v[(p + k) % NQ]) return (p + k) % NQ;
    return -1;
  endfunction

  logic [NQ-1:0] obs_rdy;
  logic          obs_we, obs_busy, obs_done;
  logic [W-1:0]  obs_s;
  int            last_grant;

  task automatic step(input logic r, input logic ini, input logic [NQ-1:0] v);
    int g;
    logic [NQ-1:0] e_rdy;
    rst = r;
    init_req = ini;
    req_vld = v;
    @(negedge clk);
    g = rr_pick(v, m_ptr);
    e_rdy = (m_phase < 0 && !ini && g >= 0) ? NQ'(1 << g) : '0;
    chk("req_rdy", 64'(req_rdy), 64'(e_rdy));
    chk("rf_we", 64'(rf_we), 64'(e_we));
    chk("rf_s", 64'(rf_s), 64'(e_s));
    chk("rf_d", rf_d, e_d);
    chk("busy", 64'(busy), 64'(m_phase >= 0));
    chk("init_done", 64'(init_done), 64'(e_done));
    obs_rdy = req_rdy; obs_we = rf_we; obs_s = rf_s;
    obs_busy = busy; obs_done = init_done;
    last_grant = (e_rdy != '0) ? g : -1;
    @(posedge clk);
    if (e_we) m_mem[e_s] = e_d;
    if (r) begin
      m_ptr = 0; m_phase = -1; e_we = 0; e_s = '0; e_d = '0; e_done = 0;
    end else if (m_phase >= 0) begin
      e_done = 0;
      if (m_phase < NR) begin
        e_we = 1; e_s = W'(m_phase); e_d = '0;
        e_done = (m_phase == NR - 1);
        m_phase++;
      end else begin
        e_we = 0; m_phase = -1;
      end
    end else if (ini) begin
      m_phase = 0; e_we = 0; e_done = 0;
    end else if (g >= 0) begin
      e_we = 1; e_s = a_q[g]; e_d = d_q[g]; e_done = 0;
      m_ptr = (g + 1) % NQ;
    end else begin
      e_we = 0; e_done = 0;
    end
    #1;
  endtask

  typedef struct {
    logic [NQ-1:0]   vld;
    logic [NQ*W-1:0] addr;
    logic [NQ-1:0]   exp_rdy;
    logic            exp_we;
    logic [W-1:0]    exp_s;
  } vec_t;

  vec_t tbl [13];
  logic pend [NQ];
  int nb, nd;
  logic [W-1:0] ds;

  initial begin
    tbl[0]  = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd5}, 4'b0001, 1'b0, 3'd0};
    tbl[1]  = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0010, 1'b1, 3'd5};
    tbl[2]  = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0100, 1'b1, 3'd1};
    tbl[3]  = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b1000, 1'b1, 3'd2};
    tbl[4]  = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0001, 1'b1, 3'd3};
    tbl[5]  = '{4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0010, 1'b1, 3'd0};
    tbl[6]  = '{4'b0100, {3'd0, 3'd6, 3'd0, 3'd0}, 4'b0100, 1'b1, 3'd1};
    tbl[7]  = '{4'b0000, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 1'b1, 3'd6};
    tbl[8]  = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd7}, 4'b0001, 1'b0, 3'd6};
    tbl[9]  = '{4'b1010, {3'd2, 3'd0, 3'd2, 3'd0}, 4'b0010, 1'b1, 3'd7};
    tbl[10] = '{4'b1000, {3'd2, 3'd0, 3'd0, 3'd0}, 4'b1000, 1'b1, 3'd2};
    tbl[11] = '{4'b0000, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 1'b1, 3'd2};
    tbl[12] = '{4'b0000, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0000, 1'b0, 3'd2};

    for (int i = 0; i < NQ; i++) begin a_q[i] = '0; d_q[i] = '0; pend[i] = 0; end
    rst = 1; init_req = 0; req_vld = '0;
    repeat (3) @(posedge clk);
    #1;
    m_ptr = 0; m_phase = -1; e_we = 0; e_s = '0; e_d = '0; e_done = 0;
    for (int k = 0; k < NR; k++) m_mem[k] = '0;

    step(1, 0, '0);
    chk("reset_we", 64'(obs_we), 64'd0);
    chk("reset_s", 64'(obs_s), 64'd0);
    chk("reset_busy", 64'(obs_busy), 64'd0);
    chk("reset_done", 64'(obs_done), 64'd0);

    for (int v = 0; v < 13; v++) begin
      for (int i = 0; i < NQ; i++) begin
        a_q[i] = tbl[v].addr[i*W +: W];
        d_q[i] = dgen(i, a_q[i]);
      end
      step(0, 0, tbl[v].vld);
      chk($sformatf("tbl%0d_rdy", v), 64'(obs_rdy), 64'(tbl[v].exp_rdy));
      chk($sformatf("tbl%0d_we", v), 64'(obs_we), 64'(tbl[v].exp_we));
      chk($sformatf("tbl%0d_s", v), 64'(obs_s), 64'(tbl[v].exp_s));
    end
    chk("q_reg5", q_reg(5), dgen(0, 3'd5));
    chk("q_reg2_last_grant_wins", q_reg(2), dgen(3, 3'd2));
    chk("q_reg6", q_reg(6), dgen(2, 3'd6));

    // Sweep requested while every requester is waiting.
    for (int i = 0; i < NQ; i++) begin a_q[i] = W'(i); d_q[i] = dgen(i, W'(i)); end
    step(0, 1, 4'b1111);
    chk("sweep_entry_rdy", 64'(obs_rdy), 64'd0);
    nb = 0; nd = 0; ds = '0;
    for (int c = 0; c < NR + 1; c++) begin
      step(0, 0, 4'b1111);
      if (obs_busy) nb++;
      if (obs_done) begin nd++; ds = obs_s; end
      chk("sweep_rdy", 64'(obs_rdy), 64'd0);
      if (c >= 1) chk("sweep_s", 64'(obs_s), 64'(c - 1));
    end
    chk("sweep_busy_cycles", 64'(nb), 64'(NR + 1));
    chk("sweep_done_pulses", 64'(nd), 64'd1);
    chk("sweep_done_addr", 64'(ds), 64'(NR - 1));
    step(0, 0, 4'b1111);
    chk("resume_rdy", 64'(obs_rdy), 64'b0001);
    chk("resume_busy", 64'(obs_busy), 64'd0);
    for (int k = 0; k < NR; k++) chk($sformatf("q_zero%0d", k), q_reg(k), '0);
    step(0, 0, '0);
    step(0, 0, '0);

    // Reset lands while the sweep is writing address 3.
    for (int k = 4; k < NR; k++) begin
      a_q[0] = W'(k); d_q[0] = dgen(0, W'(k));
      step(0, 0, 4'b0001);
    end
    step(0, 0, '0);
    step(0, 0, '0);
    step(0, 1, '0);
    repeat (4) step(0, 0, '0);
    step(1, 0, '0);
    chk("abort_at_s", 64'(obs_s), 64'd3);
    chk("abort_at_we", 64'(obs_we), 64'd1);
    step(0, 0, '0);
    chk("abort_we", 64'(obs_we), 64'd0);
    chk("abort_busy", 64'(obs_busy), 64'd0);
    chk("abort_done", 64'(obs_done), 64'd0);
    step(0, 0, '0);
    for (int k = 0; k < 4; k++) chk($sformatf("abort_q%0d", k), q_reg(k), '0);
    for (int k = 4; k < NR; k++) chk($sformatf("abort_q%0d", k), q_reg(k), dgen(0, W'(k)));

    // Random traffic; each requester holds its request until granted.
    for (int n = 0; n < 600; n++) begin
      logic [NQ-1:0] v;
      logic r, ini;
      for (int i = 0; i < NQ; i++) begin
        if (!pend[i] && $urandom_range(1) == 1) begin
          pend[i] = 1;
          a_q[i] = W'($urandom_range(NR - 1));
          d_q[i] = {$urandom, $urandom};
        end
        v[i] = pend[i];
      end
      ini = ($urandom_range(39) == 0);
      r = ($urandom_range(199) == 0);
      step(r, ini, v);
      if (last_grant >= 0) pend[last_grant] = 0;
    end
    repeat (NR + 4) step(0, 0, '0);
    for (int k = 0; k < NR; k++) chk($sformatf("final_q%0d", k), q_reg(k), m_mem[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
